// File: rtl/ibex_instr_bus_arbiter.sv
// Two-requester OBI instruction-bus arbiter with in-order response routing.
// Define IBUS_ARB_PERF_EN to add grant/stall performance counters.
module ibex_instr_bus_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          FixedPrio      = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
`ifdef IBUS_ARB_PERF_EN
  output logic [31:0] perf_gnt0_o,
  output logic [31:0] perf_gnt1_o,
  output logic [31:0] perf_stall_o,
`endif
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PW =
    (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CW-1:0] MaxCnt  = CW'(MaxOutstanding);
  localparam logic [PW-1:0] LastPtr = PW'(MaxOutstanding - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e        state_q, state_d;
  logic          lock_id_q, lock_id_d;
  logic [31:0]   lock_addr_q, lock_addr_d;
  logic          lock_drop_q, lock_drop_d;
  logic          rr_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] wptr_q, rptr_q;
  logic          fifo_id_q   [MaxOutstanding];
  logic          fifo_drop_q [MaxOutstanding];

  logic        full, any_req, win, lock_req;
  logic        push, push_id, push_drop, pop;
  logic        head_id, head_drop;
  logic        req, gnt0, gnt1;
  logic [31:0] addr;

  assign full    = (cnt_q == MaxCnt);
  assign any_req = m0_req_i | m1_req_i;
  assign lock_req = lock_id_q ? m1_req_i : m0_req_i;

  always_comb begin
    win = 1'b0;
    if (m0_req_i && m1_req_i) begin
      win = FixedPrio ? 1'b0 : rr_q;
    end else begin
      win = m1_req_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_id_d   = lock_id_q;
    lock_addr_d = lock_addr_q;
    lock_drop_d = lock_drop_q;
    req         = 1'b0;
    addr        = '0;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    push        = 1'b0;
    push_id     = 1'b0;
    push_drop   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!full && any_req) begin
          req  = 1'b1;
          addr = win ? m1_addr_i : m0_addr_i;
          if (instr_gnt_i) begin
            push    = 1'b1;
            push_id = win;
            gnt0    = ~win;
            gnt1    = win;
          end else begin
            state_d     = LOCKED;
            lock_id_d   = win;
            lock_addr_d = addr;
            lock_drop_d = 1'b0;
          end
        end
      end
      LOCKED: begin
        // Request stays up until granted, even if the requester withdrew.
        req  = 1'b1;
        addr = lock_addr_q;
        if (instr_gnt_i) begin
          push      = 1'b1;
          push_id   = lock_id_q;
          push_drop = lock_drop_q | ~lock_req;
          gnt0      = ~push_drop & ~lock_id_q;
          gnt1      = ~push_drop & lock_id_q;
          state_d   = IDLE;
        end else begin
          lock_drop_d = lock_drop_q | ~lock_req;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop       = instr_rvalid_i && (cnt_q != '0);
  assign head_id   = fifo_id_q[rptr_q];
  assign head_drop = fifo_drop_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lock_id_q   <= 1'b0;
      lock_addr_q <= '0;
      lock_drop_q <= 1'b0;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      lock_id_q   <= lock_id_d;
      lock_addr_q <= lock_addr_d;
      lock_drop_q <= lock_drop_d;
      if (push) begin
        rr_q   <= ~push_id;
        wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_id_q[wptr_q]   <= push_id;
      fifo_drop_q[wptr_q] <= push_drop;
    end
  end

  assign instr_req_o  = req;
  assign instr_addr_o = addr;
  assign m0_gnt_o     = gnt0;
  assign m1_gnt_o     = gnt1;
  assign m0_rvalid_o  = pop & ~head_drop & ~head_id;
  assign m1_rvalid_o  = pop & ~head_drop & head_id;
  assign m0_err_o     = m0_rvalid_o & instr_err_i;
  assign m1_err_o     = m1_rvalid_o & instr_err_i;
  assign m0_rdata_o   = instr_rdata_i;
  assign m1_rdata_o   = instr_rdata_i;
  assign busy_o       = (cnt_q != '0) || (state_q == LOCKED);

`ifdef IBUS_ARB_PERF_EN
  logic [31:0] pg0_q, pg1_q, pst_q;
  logic        stall;

  assign stall = any_req & ~(gnt0 | gnt1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pg0_q <= '0;
      pg1_q <= '0;
      pst_q <= '0;
    end else begin
      if (gnt0 && pg0_q != 32'hFFFF_FFFF) pg0_q <= pg0_q + 1'b1;
      if (gnt1 && pg1_q != 32'hFFFF_FFFF) pg1_q <= pg1_q + 1'b1;
      if (stall && pst_q != 32'hFFFF_FFFF) pst_q <= pst_q + 1'b1;
    end
  end

  assign perf_gnt0_o  = pg0_q;
  assign perf_gnt1_o  = pg1_q;
  assign perf_stall_o = pst_q;
`endif

endmodule
